// File: rtl/move_controller.sv
// Click sequencer for the chess board: turns synchronised mouse clicks into
// one-cycle pick/place commands, checks colour, legality and turn order.
module move_controller #(
  parameter int TIMEOUT = 16,
  parameter int MC_W    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mouse_left,
  input  logic [5:0]              cursor_pos,
  input  logic                    cursor_on_board,
  input  logic [0:7][0:7][3:0]    board,
  input  logic [63:0]             possible_moves,
  input  logic                    moves_valid,
  output logic                    pick_piece,
  output logic                    place_piece,
  output logic [5:0]              figure_position,
  output logic                    turn,
  output logic [MC_W-1:0]         move_count,
  output logic                    illegal,
  output logic                    holding
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, PICK, WAIT_MOVES, HOLD, PLACE} state_t;

  state_t          state, state_d;
  logic            m1, m2, m3;
  logic [5:0]      origin, origin_d;
  logic [5:0]      fp_d;
  logic            turn_d;
  logic [MC_W-1:0] mc_d;
  logic            pick_d, place_d, illegal_d, holding_d;
  logic            mask_ok, mask_ok_d;
  logic [TW-1:0]   timer, timer_d;
  logic            click, own, legal;
  logic [3:0]      code;

  // White codes 1..6, black codes 7..12; empty and unused codes are never own.
  function automatic logic is_own(input logic [3:0] c, input logic side);
    if (side) is_own = (c >= 4'd7) && (c <= 4'd12);
    else      is_own = (c >= 4'd1) && (c <= 4'd6);
  endfunction

  assign code  = board[cursor_pos[5:3]][cursor_pos[2:0]];
  assign own   = is_own(code, turn);
  // Square p maps to mask bit 63-p, which for 6 bits is simply ~p.
  assign legal = possible_moves[~cursor_pos];
  assign click = m2 & ~m3 & cursor_on_board;

  // Synchroniser and edge-detect stage for the mouse button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m1 <= 1'b0;
      m2 <= 1'b0;
      m3 <= 1'b0;
    end else begin
      m1 <= mouse_left;
      m2 <= m1;
      m3 <= m2;
    end
  end

  always_comb begin
    state_d   = state;
    origin_d  = origin;
    fp_d      = figure_position;
    turn_d    = turn;
    mc_d      = move_count;
    pick_d    = 1'b0;
    place_d   = 1'b0;
    illegal_d = 1'b0;
    holding_d = holding;
    mask_ok_d = mask_ok;
    timer_d   = timer;
    case (state)
      IDLE: begin
        if (click && own) begin
          origin_d  = cursor_pos;
          fp_d      = cursor_pos;
          pick_d    = 1'b1;
          holding_d = 1'b1;
          state_d   = PICK;
        end
      end
      PICK: begin
        timer_d = '0;
        state_d = WAIT_MOVES;
      end
      WAIT_MOVES: begin
        if (moves_valid) begin
          mask_ok_d = 1'b1;
          state_d   = HOLD;
        end else if (timer == TIMER_LAST) begin
          // No mask arrived: only returning the piece to its origin is allowed.
          mask_ok_d = 1'b0;
          state_d   = HOLD;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      HOLD: begin
        if (click) begin
          if (cursor_pos == origin) begin
            fp_d    = origin;
            place_d = 1'b1;
            state_d = PLACE;
          end else if (mask_ok && legal) begin
            fp_d    = cursor_pos;
            place_d = 1'b1;
            turn_d  = ~turn;
            mc_d    = move_count + MC_W'(1);
            state_d = PLACE;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      PLACE: begin
        holding_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered command/status stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      origin          <= '0;
      figure_position <= '0;
      turn            <= 1'b0;
      move_count      <= '0;
      pick_piece      <= 1'b0;
      place_piece     <= 1'b0;
      illegal         <= 1'b0;
      holding         <= 1'b0;
      mask_ok         <= 1'b0;
      timer           <= '0;
    end else begin
      state           <= state_d;
      origin          <= origin_d;
      figure_position <= fp_d;
      turn            <= turn_d;
      move_count      <= mc_d;
      pick_piece      <= pick_d;
      place_piece     <= place_d;
      illegal         <= illegal_d;
      holding         <= holding_d;
      mask_ok         <= mask_ok_d;
      timer           <= timer_d;
    end
  end

endmodule

// File: tb/tb_move_controller.sv
// Directed bench for move_controller: a table of click steps with expected
// pulses and status, plus hand-written reset and long-press sequences.
module tb_move_controller;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 mouse_left = 1'b0;
  logic [5:0]           cursor_pos = '0;
  logic                 cursor_on_board = 1'b0;
  logic [0:7][0:7][3:0] board;
  logic [63:0]          possible_moves = '0;
  logic                 moves_valid = 1'b0;
  logic                 pick_piece, place_piece, turn, illegal, holding;
  logic [5:0]           figure_position;
  logic [9:0]           move_count;

  int n_cmp = 0;
  int n_err = 0;

  move_controller #(.TIMEOUT(16), .MC_W(10)) dut (
    .clk(clk), .rst(rst), .mouse_left(mouse_left), .cursor_pos(cursor_pos),
    .cursor_on_board(cursor_on_board), .board(board),
    .possible_moves(possible_moves), .moves_valid(moves_valid),
    .pick_piece(pick_piece), .place_piece(place_piece),
    .figure_position(figure_position), .turn(turn), .move_count(move_count),
    .illegal(illegal), .holding(holding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rs;
    logic [5:0]  pos;
    logic        ob;
    logic        mv;
    logic [63:0] mask;
    int          wt;
    int          e_pick, e_place, e_ill;
    logic [5:0]  e_fp;
    logic        e_turn;
    logic [9:0]  e_mc;
    logic        e_hold;
  } step_t;

  function automatic step_t mk(input logic rs, input logic [5:0] pos, input logic ob,
                               input logic mv, input logic [63:0] mask, input int wt,
                               input int ep, input int eq, input int ei,
                               input logic [5:0] fp, input logic t, input logic [9:0] mc,
                               input logic h);
    step_t s;
    s.rs = rs; s.pos = pos; s.ob = ob; s.mv = mv; s.mask = mask; s.wt = wt;
    s.e_pick = ep; s.e_place = eq; s.e_ill = ei;
    s.e_fp = fp; s.e_turn = t; s.e_mc = mc; s.e_hold = h;
    return s;
  endfunction

  task automatic chk(input int idx, input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL step %0d %s: got %0d, expected %0d", idx, name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One button press held 8 cycles, released 4; pulses are counted per cycle.
  task automatic apply_step(input int idx, input step_t s);
    int np, nq, ni, nboth, first;
    logic [5:0] fpc;
    np = 0; nq = 0; ni = 0; nboth = 0; first = -1; fpc = '0;
    if (s.rs) pulse_reset();
    @(negedge clk);
    cursor_pos      = s.pos;
    cursor_on_board = s.ob;
    moves_valid     = s.mv;
    possible_moves  = s.mask;
    repeat (s.wt) @(negedge clk);
    mouse_left = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (pick_piece)  begin np++; fpc = figure_position; if (first < 0) first = k; end
      if (place_piece) begin nq++; fpc = figure_position; if (first < 0) first = k; end
      if (illegal)     begin ni++; if (first < 0) first = k; end
      if (pick_piece && place_piece) nboth++;
      if (k == 8) mouse_left = 1'b0;
    end
    chk(idx, "pick_count", np, s.e_pick);
    chk(idx, "place_count", nq, s.e_place);
    chk(idx, "illegal_count", ni, s.e_ill);
    chk(idx, "pick_place_overlap", nboth, 0);
    if (s.e_pick + s.e_place + s.e_ill > 0) chk(idx, "latency", first, 3);
    if (np + nq > 0) chk(idx, "fp_at_cmd", int'(fpc), int'(s.e_fp));
    chk(idx, "fp_held", int'(figure_position), int'(s.e_fp));
    chk(idx, "turn", int'(turn), int'(s.e_turn));
    chk(idx, "move_count", int'(move_count), int'(s.e_mc));
    chk(idx, "holding", int'(holding), int'(s.e_hold));
  endtask

  task automatic chk_reset_vals(input int idx);
    chk(idx, "rst_pick", int'(pick_piece), 0);
    chk(idx, "rst_place", int'(place_piece), 0);
    chk(idx, "rst_illegal", int'(illegal), 0);
    chk(idx, "rst_holding", int'(holding), 0);
    chk(idx, "rst_fp", int'(figure_position), 0);
    chk(idx, "rst_turn", int'(turn), 0);
    chk(idx, "rst_move_count", int'(move_count), 0);
  endtask

  step_t tbl[16];
  localparam logic [63:0] M_E2  = (64'd1 << 19) | (64'd1 << 27);
  localparam logic [63:0] M_E7  = (64'd1 << 35);
  localparam logic [63:0] M_G1  = (64'd1 << 18) | (64'd1 << 16);
  localparam logic [63:0] M_E3  = (64'd1 << 19);

  initial begin
    int npk;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) board[r][c] = 4'd0;
    for (int c = 0; c < 8; c++) begin
      board[1][c] = 4'd7;
      board[6][c] = 4'd1;
    end
    board[7][0] = 4'd2; board[7][1] = 4'd3; board[7][2] = 4'd4; board[7][3] = 4'd5;
    board[7][4] = 4'd6; board[7][5] = 4'd4; board[7][6] = 4'd3; board[7][7] = 4'd2;
    board[0][0] = 4'd8; board[0][1] = 4'd9; board[0][2] = 4'd10; board[0][3] = 4'd11;
    board[0][4] = 4'd12; board[0][5] = 4'd10; board[0][6] = 4'd9; board[0][7] = 4'd8;

    //             rs  pos ob mv mask  wt pk pl il fp  t  mc  h
    tbl[0]  = mk(1, 12, 1, 0, '0,    2, 0, 0, 0, 0,  0, 0, 0); // black piece, white to move
    tbl[1]  = mk(0, 40, 1, 0, '0,    0, 0, 0, 0, 0,  0, 0, 0); // empty square
    tbl[2]  = mk(0, 52, 0, 0, '0,    0, 0, 0, 0, 0,  0, 0, 0); // off board
    tbl[3]  = mk(0, 52, 1, 1, M_E2,  0, 1, 0, 0, 52, 0, 0, 1); // pick e2
    tbl[4]  = mk(0, 30, 0, 1, M_E2,  0, 0, 0, 0, 52, 0, 0, 1); // off board in HOLD
    tbl[5]  = mk(0, 36, 1, 1, M_E2,  0, 0, 1, 0, 36, 1, 1, 0); // drop e4
    tbl[6]  = mk(0, 52, 1, 1, M_E2,  0, 0, 0, 0, 36, 1, 1, 0); // white piece, black to move
    tbl[7]  = mk(0, 12, 1, 1, M_E7,  0, 1, 0, 0, 12, 1, 1, 1); // pick e7
    tbl[8]  = mk(0, 28, 1, 1, M_E7,  0, 0, 1, 0, 28, 0, 2, 0); // drop e5
    tbl[9]  = mk(1, 62, 1, 1, M_G1,  0, 1, 0, 0, 62, 0, 0, 1); // pick g1
    tbl[10] = mk(0, 30, 1, 1, M_G1,  0, 0, 0, 1, 62, 0, 0, 1); // not in mask
    tbl[11] = mk(0, 62, 1, 1, M_G1,  0, 0, 1, 0, 62, 0, 0, 0); // cancel
    tbl[12] = mk(1, 52, 1, 0, '0,    0, 1, 0, 0, 52, 0, 0, 1); // pick, no mask
    tbl[13] = mk(0, 44, 1, 0, M_E3,  0, 0, 0, 0, 52, 0, 0, 1); // click during WAIT_MOVES
    tbl[14] = mk(0, 44, 1, 0, M_E3,  20, 0, 0, 1, 52, 0, 0, 1); // after timeout, mask ignored
    tbl[15] = mk(0, 52, 1, 0, M_E3,  0, 0, 1, 0, 52, 0, 0, 0); // cancel after timeout

    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk_reset_vals(-1);

    for (int i = 0; i < 16; i++) apply_step(i, tbl[i]);

    // Reset while a piece is lifted after one completed move
    apply_step(100, mk(1, 52, 1, 1, M_E2, 0, 1, 0, 0, 52, 0, 0, 1));
    apply_step(101, mk(0, 36, 1, 1, M_E2, 0, 0, 1, 0, 36, 1, 1, 0));
    apply_step(102, mk(0, 12, 1, 1, M_E7, 0, 1, 0, 0, 12, 1, 1, 1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_vals(103);
    @(negedge clk);
    rst = 1'b0;

    // Long press: 50 cycles held over an own piece yields one pick
    moves_valid     = 1'b0;
    cursor_pos      = 6'd52;
    cursor_on_board = 1'b1;
    mouse_left      = 1'b1;
    npk = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (pick_piece) npk++;
    end
    mouse_left = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (pick_piece) npk++;
    end
    chk(104, "long_press_picks", npk, 1);
    chk(104, "long_press_fp", int'(figure_position), 52);
    chk(104, "long_press_holding", int'(holding), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/move_controller.md
# move_controller

Turn-aware click sequencer that sits directly upstream of the chess board register file. It converts synchronised mouse clicks on board squares into single-cycle `pick_piece` and `place_piece` commands with a matching `figure_position`. It validates the piece colour against the side to move and checks every drop against the legal-move mask from the move generator. It also tracks turn and move count for the rest of the game logic.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum cycles to wait for `moves_valid` after a pick.
- `MC_W`, 10: width of `move_count`.

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `mouse_left`  in  1: raw left-button level from the mouse domain.
- `cursor_pos`  in  6: square under the cursor; [5:3] is row, [2:0] is column.
- `cursor_on_board`  in  1: cursor lies inside the 8x8 area.
- `board`  in  4 x [0:7][0:7]: current piece codes.
  - 0 is empty.
  - 1–6 are white.
  - 7–C are black.
  - D is never stored.
- `possible_moves`  in  64: legal-target mask; square p maps to bit 63-p.
- `moves_valid`  in  1: mask is valid for the current pick; level.
- `pick_piece`  out  1: one-cycle pick command.
- `place_piece`  out  1: one-cycle place command.
- `figure_position`  out  6: square for pick/place; held between commands.
- `turn`  out  1: 0 = white to move, 1 = black.
- `move_count`  out  MC_W: completed moves.
- `illegal`  out  1: one-cycle pulse on a rejected drop.
- `holding`  out  1: a piece is currently lifted.

## Operation
- **Click detection:** `mouse_left` passes through a 3-flop chain m1→m2→m3. `click = m2 & ~m3 & cursor_on_board`.
- **Colour test:** code `c` at `cursor_pos` is own when `turn==0` and 1≤c≤6, or when `turn==1` and 7≤c≤12.
- **Legality:** `legal = possible_moves[63-cursor_pos]`.
- **State machine:** IDLE, PICK, WAIT_MOVES, HOLD, PLACE.
  - **IDLE:** on `click` with an own piece at the cursor:
    - Latch `origin <= cursor_pos` and `figure_position <= cursor_pos`.
    - Register `pick_piece <= 1` and go to PICK.
    - A click on an empty or opponent square is ignored silently.
  - **PICK:** one cycle with `pick_piece` high; `holding` is high from here on. Go to WAIT_MOVES.
  - **WAIT_MOVES:** load timer to 0 on entry and increment each cycle.
    - If `moves_valid` is high: go to HOLD with `mask_ok=1`.
    - If the timer reaches TIMEOUT-1 first: go to HOLD with `mask_ok=0`; only a drop on `origin` is then accepted.
    - Clicks are ignored in this state.
  - **HOLD:** on `click`:
    - If `cursor_pos==origin`: this is a cancel. Set `figure_position <= origin`, `place_piece <= 1`, go to PLACE. Turn and count are unchanged.
    - Else if `mask_ok & legal`: set `figure_position <= cursor_pos` and `place_piece <= 1`. Toggle `turn`, increment `move_count`, go to PLACE.
    - Otherwise: pulse `illegal` for one cycle and stay in HOLD.
    - A drop onto an own piece is rejected only through the mask; no separate colour check is made.
  - **PLACE:** one cycle with `place_piece` high, then IDLE. `holding` clears on PLACE→IDLE.
- **Counter arithmetic:** `move_count` wraps modulo 2^MC_W. `turn` toggles on every accepted non-cancel drop.
- `pick_piece` and `place_piece` are never high in the same cycle.

## Timing
- **Reset values:**
  - State IDLE.
  - `pick_piece`, `place_piece`, `illegal`, `holding` = 0.
  - `figure_position` = 0, `origin` = 0, `turn` = 0, `move_count` = 0.
  - m1..m3 = 0, `mask_ok` = 0, timer = 0.
- **Click latency:** `mouse_left` rises before clock edge E0. `click` is true between E1 and E2. The command registered at E2 is high for exactly one cycle after E2.
- **Output alignment:** all outputs are registered. `figure_position` is stable in the cycle where `pick_piece` or `place_piece` is high, and stays held afterwards.
- **Mask timing:** earliest HOLD entry is 2 cycles after `pick_piece`, provided `moves_valid` is already high in WAIT_MOVES. Worst case is TIMEOUT cycles.
- **Long press:** a held button produces one `click` only; the next click needs a release of at least 1 cycle beyond the sync depth.
- **Reset mid-operation:** `rst` in any state returns everything to reset values immediately, including a lifted piece. The board is reset by the same `rst`, so no piece is lost.
- **Off-board click:** a click with `cursor_on_board=0` is dropped in every state.

## Test plan
1. **Reset:** release reset, idle 10 cycles → all outputs 0, state IDLE.
2. **White move e2–e4:**
   - Click at `cursor_pos`=52 (code 1) → `pick_piece` pulse with `figure_position`=52 on the 3rd edge after the rise.
   - Drive `moves_valid`=1 with bits for squares 44 and 36 set (bits 19 and 27).
   - Click 36 → `place_piece` pulse with `figure_position`=36, `turn`=1, `move_count`=1.
3. **Wrong colour:** with `turn`=0, click square 12 (code 7) → no pick, state IDLE; repeat on empty square 40 → no pick.
4. **Illegal then cancel:**
   - Pick square 62 (code 3) with mask bits for 45 and 47 only.
   - Click 30 → `illegal` pulse, `holding`=1.
   - Click 62 → `place_piece` with `figure_position`=62, `turn` and `move_count` unchanged.
5. **Timeout:**
   - Pick 52 and hold `moves_valid`=0 for 20 cycles → HOLD after 16 cycles.
   - Click 44 → `illegal`.
   - Click 52 → cancel accepted.
6. **Reset mid-HOLD and long press:**
   - Assert `rst` in HOLD → outputs back to reset values within that cycle, `holding`=0.
   - Then hold `mouse_left` for 50 cycles over square 52 → exactly one `pick_piece`.
